// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single on-chip RAM slave port between two requesters:
//   m0 (CPU data port) and m1 (DMA/peripheral master). One command is
//   granted per cycle. The granted command is driven onto ram_slave_*,
//   and read data is steered back to the issuing port RD_LAT cycles later.
//
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate,
//                                        favouring the port that is not
//                                        last_owner.
//                           undefined -> fixed priority, m0 always wins.
//
// Parameters:
//   ADDR_W  RAM word-address width
//   DATA_W  data width (byteenable width is DATA_W/8)
//   RD_LAT  RAM read latency in cycles (1 or 2)
//
// Ports:
//   clk_arb_clk, rst_arb_reset_n      clock, asynchronous active-low reset
//   mN_req/write/address/writedata/byteenable   requester N command (N=0,1)
//   mN_gnt                            command accepted this cycle (combinational)
//   mN_rvalid, mN_readdata            read return for requester N
//   ram_slave_*                       RAM slave command / read data
module ram_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk_arb_clk,
   input  logic                rst_arb_reset_n,

   input  logic                m0_req,
   input  logic                m0_write,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_readdata,

   input  logic                m1_req,
   input  logic                m1_write,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_readdata,

   output logic [ADDR_W-1:0]   ram_slave_address,
   output logic                ram_slave_clken,
   output logic                ram_slave_chipselect,
   output logic                ram_slave_write,
   output logic [DATA_W-1:0]   ram_slave_writedata,
   output logic [DATA_W/8-1:0] ram_slave_byteenable,
   input  logic [DATA_W-1:0]   ram_slave_readdata
);

   localparam int BE_W = DATA_W / 8;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   // last_owner: 0 = m0, 1 = m1. Kept in both builds; only consulted
   // under round robin.
   logic              last_owner;
   logic              m0_win;

   // Read-return tracker: index 0 is loaded at the command edge, index
   // RD_LAT-1 is the head whose data is on ram_slave_readdata.
   logic [RD_LAT-1:0] vld_p;
   logic [RD_LAT-1:0] own_p;

   // m0 wins whenever it requests, unless round robin is enabled, m1 is
   // also requesting and m0 was the previous owner.
   always_comb begin
      m0_win = m0_req & (~RR_EN | ~m1_req | last_owner);
   end

   // Grants are masked by reset so no strobe escapes while it is asserted.
   assign m0_gnt = rst_arb_reset_n & m0_win;
   assign m1_gnt = rst_arb_reset_n & m1_req & ~m0_win;

   assign ram_slave_chipselect = m0_gnt | m1_gnt;
   assign ram_slave_clken      = rst_arb_reset_n;

   always_comb begin
      ram_slave_address    = '0;
      ram_slave_write      = 1'b0;
      ram_slave_writedata  = '0;
      ram_slave_byteenable = '0;
      if (m0_gnt) begin
         ram_slave_address    = m0_address;
         ram_slave_write      = m0_write;
         ram_slave_writedata  = m0_writedata;
         ram_slave_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
      end else if (m1_gnt) begin
         ram_slave_address    = m1_address;
         ram_slave_write      = m1_write;
         ram_slave_writedata  = m1_writedata;
         ram_slave_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
      end
   end

   // Command edge -> read-return tracker
   always_ff @(posedge clk_arb_clk or negedge rst_arb_reset_n) begin
      if (!rst_arb_reset_n) begin
         last_owner <= 1'b0;
         vld_p      <= '0;
         own_p      <= '0;
      end else begin
         if (ram_slave_chipselect) begin
            last_owner <= m1_gnt;
         end
         vld_p[0] <= ram_slave_chipselect & ~ram_slave_write;
         own_p[0] <= m1_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            own_p[i] <= own_p[i-1];
         end
      end
   end

   // Head of tracker -> read return
   assign m0_rvalid   = vld_p[RD_LAT-1] & ~own_p[RD_LAT-1];
   assign m1_rvalid   = vld_p[RD_LAT-1] &  own_p[RD_LAT-1];
   assign m0_readdata = ram_slave_readdata;
   assign m1_readdata = ram_slave_readdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 2;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              m0_req, m0_write, m1_req, m1_write;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic [3:0]        m0_byteenable, m1_byteenable;
   logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_clken, ram_cs, ram_write;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic [3:0]        ram_be;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk_arb_clk          (clk),
      .rst_arb_reset_n      (rst_n),
      .m0_req               (m0_req),
      .m0_write             (m0_write),
      .m0_address           (m0_address),
      .m0_writedata         (m0_writedata),
      .m0_byteenable        (m0_byteenable),
      .m0_gnt               (m0_gnt),
      .m0_rvalid            (m0_rvalid),
      .m0_readdata          (m0_readdata),
      .m1_req               (m1_req),
      .m1_write             (m1_write),
      .m1_address           (m1_address),
      .m1_writedata         (m1_writedata),
      .m1_byteenable        (m1_byteenable),
      .m1_gnt               (m1_gnt),
      .m1_rvalid            (m1_rvalid),
      .m1_readdata          (m1_readdata),
      .ram_slave_address    (ram_addr),
      .ram_slave_clken      (ram_clken),
      .ram_slave_chipselect (ram_cs),
      .ram_slave_write      (ram_write),
      .ram_slave_writedata  (ram_wdata),
      .ram_slave_byteenable (ram_be),
      .ram_slave_readdata   (ram_rdata)
   );

   // RAM model with byte-lane writes and RD_LAT-cycle registered reads.
   logic [DATA_W-1:0] mem [0:1023];
   logic [DATA_W-1:0] rd_q1, rd_q2;
   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [DATA_W-1:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_clken && ram_cs) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end else begin
            rd_q1 <= mem[ram_addr];
         end
      end
      rd_q2 <= rd_q1;
   end
   assign ram_rdata = (RD_LAT == 1) ? rd_q1 : rd_q2;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m0_req = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
      m1_req = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic do_reset;
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      idle();
      rst_n = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1; m1_write = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin failures++;
         $display("FAIL rst_gnt got=%b%b exp=00", m0_gnt, m1_gnt); end
      checks++; if (ram_cs !== 1'b0 || ram_write !== 1'b0 || ram_clken !== 1'b0) begin failures++;
         $display("FAIL rst_strobes cs/wr/clken got=%b%b%b exp=000", ram_cs, ram_write, ram_clken); end
      checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin failures++;
         $display("FAIL rst_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      checks++; if (ram_clken !== 1'b1 || ram_cs !== 1'b0) begin failures++;
         $display("FAIL idle_clken_cs got=%b%b exp=10", ram_clken, ram_cs); end
      checks++; if (ram_addr !== '0 || ram_be !== 4'h0 || ram_wdata !== '0) begin failures++;
         $display("FAIL idle_bus addr=%h be=%h wd=%h exp=0", ram_addr, ram_be, ram_wdata); end
      tick();
   endtask

   task automatic test_single_read;
      m0_req = 1'b1; m0_write = 1'b0; m0_address = 10'h005; m0_byteenable = 4'h0;
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++;
         $display("FAIL rd_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
      checks++; if (ram_cs !== 1'b1 || ram_write !== 1'b0 || ram_addr !== 10'h005) begin failures++;
         $display("FAIL rd_cmd cs=%b wr=%b addr=%h exp=1/0/005", ram_cs, ram_write, ram_addr); end
      checks++; if (ram_be !== 4'hF) begin failures++;
         $display("FAIL rd_be_forced got=%h exp=f", ram_be); end
      tick();
      idle();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         @(negedge clk);
         checks++; if (m0_rvalid !== (k == RD_LAT) || m1_rvalid !== 1'b0) begin failures++;
            $display("FAIL rd_rvalid k=%0d got=%b%b exp=%b0", k, m0_rvalid, m1_rvalid, (k == RD_LAT)); end
         if (k == RD_LAT) begin
            checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++;
               $display("FAIL rd_data got=%h exp=deadbeef", m0_readdata); end
         end
         tick();
      end
   endtask

   task automatic test_byte_write;
      m1_req = 1'b1; m1_write = 1'b1; m1_address = 10'h3FF;
      m1_writedata = 32'h11223344; m1_byteenable = 4'b0100;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin failures++;
         $display("FAIL wr_gnt got=%b%b exp=01", m0_gnt, m1_gnt); end
      checks++; if (ram_write !== 1'b1 || ram_be !== 4'b0100 || ram_addr !== 10'h3FF
                    || ram_wdata !== 32'h11223344) begin failures++;
         $display("FAIL wr_cmd wr=%b be=%b addr=%h wd=%h", ram_write, ram_be, ram_addr, ram_wdata); end
      tick();
      idle();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         @(negedge clk);
         checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin failures++;
            $display("FAIL wr_no_rvalid k=%0d got=%b%b exp=00", k, m0_rvalid, m1_rvalid); end
         tick();
      end
      m1_req = 1'b1; m1_write = 1'b0; m1_address = 10'h3FF; m1_byteenable = 4'h0;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1 || ram_be !== 4'hF) begin failures++;
         $display("FAIL wr_rdback_cmd gnt=%b be=%h exp=1/f", m1_gnt, ram_be); end
      tick();
      idle();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         @(negedge clk);
         checks++; if (m1_rvalid !== (k == RD_LAT) || m0_rvalid !== 1'b0) begin failures++;
            $display("FAIL wr_rdback_rvalid k=%0d got=%b%b", k, m0_rvalid, m1_rvalid); end
         if (k == RD_LAT) begin
            checks++; if (m1_readdata !== 32'h00220000) begin failures++;
               $display("FAIL wr_rdback_data got=%h exp=00220000", m1_readdata); end
         end
         tick();
      end
   endtask

   task automatic test_contention;
      logic exp_v   [0:15];
      logic exp_own [0:15];
      logic eg0, eg1, rv0, rv1;
      do_reset();
      for (int i = 0; i < 16; i++) begin exp_v[i] = 1'b0; exp_own[i] = 1'b0; end
      for (int i = 0; i < 7 + RD_LAT + 1; i++) begin
         idle();
         m0_req = (i < 6); m0_address = 10'h010;
         m1_req = (i < 7); m1_address = 10'h020;
         if (i < 7) eg1 = RR ? (i % 2 == 0) : (i == 6);
         else       eg1 = 1'b0;
         eg0 = (i < 6) && !eg1;
         exp_v[i] = eg0 | eg1; exp_own[i] = eg1;
         @(negedge clk);
         checks++; if (m0_gnt !== eg0 || m1_gnt !== eg1) begin failures++;
            $display("FAIL cont_gnt cyc=%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, eg0, eg1); end
         rv0 = 1'b0; rv1 = 1'b0;
         if (i >= RD_LAT && exp_v[i-RD_LAT]) begin
            rv0 = !exp_own[i-RD_LAT]; rv1 = exp_own[i-RD_LAT];
         end
         checks++; if (m0_rvalid !== rv0 || m1_rvalid !== rv1) begin failures++;
            $display("FAIL cont_rvalid cyc=%0d got=%b%b exp=%b%b", i, m0_rvalid, m1_rvalid, rv0, rv1); end
         if (rv0 && m0_readdata !== 32'hA0000010) begin failures++;
            $display("FAIL cont_data0 cyc=%0d got=%h exp=a0000010", i, m0_readdata); end
         if (rv1 && m1_readdata !== 32'hB0000020) begin failures++;
            $display("FAIL cont_data1 cyc=%0d got=%h exp=b0000020", i, m1_readdata); end
         if (rv0 || rv1) checks++;
         tick();
      end
      idle();
   endtask

   task automatic test_back_to_back;
      // m0 reads 1, m1 reads 2, m0 reads 3 on consecutive cycles
      logic              t_r0  [0:2] = '{1'b1, 1'b0, 1'b1};
      logic [ADDR_W-1:0] t_adr [0:2] = '{10'h001, 10'h002, 10'h003};
      logic [DATA_W-1:0] t_dat [0:2] = '{32'h11110001, 32'h22220002, 32'h33330003};
      logic rv0, rv1;
      for (int i = 0; i < 3 + RD_LAT + 1; i++) begin
         idle();
         if (i < 3) begin
            m0_req = t_r0[i];  m0_address = t_adr[i];
            m1_req = !t_r0[i]; m1_address = t_adr[i];
         end
         @(negedge clk);
         if (i < 3) begin
            checks++; if (m0_gnt !== t_r0[i] || m1_gnt !== !t_r0[i]) begin failures++;
               $display("FAIL b2b_gnt cyc=%0d got=%b%b", i, m0_gnt, m1_gnt); end
         end
         rv0 = 1'b0; rv1 = 1'b0;
         if (i >= RD_LAT && i - RD_LAT < 3) begin
            rv0 = t_r0[i-RD_LAT]; rv1 = !t_r0[i-RD_LAT];
         end
         checks++; if (m0_rvalid !== rv0 || m1_rvalid !== rv1) begin failures++;
            $display("FAIL b2b_rvalid cyc=%0d got=%b%b exp=%b%b", i, m0_rvalid, m1_rvalid, rv0, rv1); end
         if (rv0 || rv1) begin
            checks++;
            if ((rv0 ? m0_readdata : m1_readdata) !== t_dat[i-RD_LAT]) begin failures++;
               $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i,
                        rv0 ? m0_readdata : m1_readdata, t_dat[i-RD_LAT]); end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid_read;
      m0_req = 1'b1; m0_address = 10'h005;
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b1) begin failures++;
         $display("FAIL mid_gnt got=%b exp=1", m0_gnt); end
      tick();
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (m0_gnt !== 1'b0 || ram_cs !== 1'b0 || ram_write !== 1'b0 || ram_clken !== 1'b0
                       || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin failures++;
            $display("FAIL mid_in_reset k=%0d gnt=%b cs=%b wr=%b clken=%b rv=%b%b", k,
                     m0_gnt, ram_cs, ram_write, ram_clken, m0_rvalid, m1_rvalid); end
         tick();
      end
      rst_n = 1'b1;
      idle();
      m1_req = 1'b1; m1_address = 10'h002;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1 || ram_cs !== 1'b1 || m0_rvalid !== 1'b0) begin failures++;
         $display("FAIL mid_post_gnt gnt1=%b cs=%b rv0=%b exp=1/1/0", m1_gnt, ram_cs, m0_rvalid); end
      tick();
      idle();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         @(negedge clk);
         checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== (k == RD_LAT)) begin failures++;
            $display("FAIL mid_post_rvalid k=%0d got=%b%b", k, m0_rvalid, m1_rvalid); end
         if (k == RD_LAT) begin
            checks++; if (m1_readdata !== 32'h22220002) begin failures++;
               $display("FAIL mid_post_data got=%h exp=22220002", m1_readdata); end
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      #1;
      preload(10'h005, 32'hDEADBEEF);
      preload(10'h3FF, 32'h00000000);
      preload(10'h010, 32'hA0000010);
      preload(10'h020, 32'hB0000020);
      preload(10'h001, 32'h11110001);
      preload(10'h002, 32'h22220002);
      preload(10'h003, 32'h33330003);
      test_reset();
      test_single_read();
      test_byte_write();
      test_contention();
      test_back_to_back();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
